// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//
// Shares one single-port synchronous RAM between an instruction-fetch port
// (read only) and a data port (load/store).
//
// Each access takes three cycles:
//   IDLE   - pick a winner and register its RAM command;
//   ACCESS - the command is on the RAM pins and the winner's gnt is high;
//   RESP   - RAM read data (one-cycle latency) returns, with a one-cycle
//            valid pulse to the winner.
// When both ports request in the same IDLE cycle they are served in
// round-robin order. After reset the fetch port wins the first contended
// grant.
//
// Ports
//   Clock, Resetn                  clock; synchronous active-low reset
//   f_req, f_addr                  fetch request and read address
//   f_gnt, f_valid, f_rdata        fetch access in progress / data valid / data
//   d_req, d_we, d_addr, d_wdata   data request, write enable, address, wdata
//   d_gnt, d_valid, d_rdata        data access in progress / done / read data
//   ram_addr, ram_wren, ram_wdata  registered RAM command
//   ram_q                          RAM read data, valid one cycle after address
//   busy                           high during ACCESS and RESP
// ---------------------------------------------------------------------------
module mem_arbiter #(
  parameter int AW = 16,
  parameter int DW = 16
) (
  input  logic          Clock,
  input  logic          Resetn,
  input  logic          f_req,
  input  logic [AW-1:0] f_addr,
  output logic          f_gnt,
  output logic          f_valid,
  output logic [DW-1:0] f_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_valid,
  output logic [DW-1:0] d_rdata,
  output logic [AW-1:0] ram_addr,
  output logic          ram_wren,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_q,
  output logic          busy
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_RESP   = 2'b10
  } state_t;

  state_t        state_r;
  state_t        state_s;
  logic          start_s;      // an arbitration happens at this edge
  logic          any_req_s;
  logic          win_data_s;   // 1 = data port wins this arbitration
  logic          last_data_r;  // 1 = data port was granted most recently
  logic          win_data_r;   // winner of the transaction in flight
  logic          win_we_r;     // transaction in flight is a store
  logic          f_gnt_r;
  logic          d_gnt_r;
  logic          f_valid_r;
  logic          d_valid_r;
  logic          busy_r;
  logic [AW-1:0] ram_addr_r;
  logic          ram_wren_r;
  logic [DW-1:0] ram_wdata_r;

  // Winner selection: a lone requester wins, contention goes to the port not served last.
  always_comb begin
    any_req_s  = f_req | d_req;
    win_data_s = 1'b0;
    if (f_req && d_req) begin
      win_data_s = ~last_data_r;
    end else if (d_req) begin
      win_data_s = 1'b1;
    end else begin
      win_data_s = 1'b0;
    end
  end

  // Next-state logic; requests only matter in IDLE.
  always_comb begin
    state_s = state_r;
    start_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (any_req_s) begin
          state_s = ST_ACCESS;
          start_s = 1'b1;
        end else begin
          state_s = ST_IDLE;
          start_s = 1'b0;
        end
      end
      ST_ACCESS: state_s = ST_RESP;
      ST_RESP:   state_s = ST_IDLE;
      default:   state_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // RAM command capture and round-robin history, all taken in IDLE so a
  // requester may drop its request mid-transaction without effect.
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      last_data_r <= 1'b1;
      win_data_r  <= 1'b0;
      win_we_r    <= 1'b0;
      ram_addr_r  <= {AW{1'b0}};
      ram_wren_r  <= 1'b0;
      ram_wdata_r <= {DW{1'b0}};
    end else if (start_s) begin
      last_data_r <= win_data_s;
      win_data_r  <= win_data_s;
      win_we_r    <= win_data_s & d_we;
      ram_wren_r  <= win_data_s & d_we;
      ram_addr_r  <= win_data_s ? d_addr : f_addr;
      ram_wdata_r <= win_data_s ? d_wdata : {DW{1'b0}};
    end else begin
      // Write enable lives only for the ACCESS cycle; address/data are held.
      ram_wren_r  <= 1'b0;
    end
  end

  // Handshake outputs, registered from the upcoming state.
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      f_gnt_r   <= 1'b0;
      d_gnt_r   <= 1'b0;
      f_valid_r <= 1'b0;
      d_valid_r <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      f_gnt_r   <= start_s & ~win_data_s;
      d_gnt_r   <= start_s & win_data_s;
      f_valid_r <= (state_r == ST_ACCESS) & ~win_data_r;
      d_valid_r <= (state_r == ST_ACCESS) & win_data_r;
      busy_r    <= (state_s != ST_IDLE);
    end
  end

  // Read data steering: ram_q only becomes valid during RESP, so it is gated
  // by the registered valid rather than re-registered (which would add a cycle).
  always_comb begin
    f_rdata = {DW{1'b0}};
    d_rdata = {DW{1'b0}};
    if (f_valid_r) begin
      f_rdata = ram_q;
    end else begin
      f_rdata = {DW{1'b0}};
    end
    if (d_valid_r && !win_we_r) begin
      d_rdata = ram_q;
    end else begin
      d_rdata = {DW{1'b0}};
    end
  end

  assign f_gnt     = f_gnt_r;
  assign d_gnt     = d_gnt_r;
  assign f_valid   = f_valid_r;
  assign d_valid   = d_valid_r;
  assign busy      = busy_r;
  assign ram_addr  = ram_addr_r;
  assign ram_wren  = ram_wren_r;
  assign ram_wdata = ram_wdata_r;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter AW, default 16, RAM address width in bits.
REQ-002 Parameter DW, default 16, RAM data width in bits.
REQ-003 Clock  input  1  single clock; all state changes on its rising edge.
REQ-004 Resetn  input  1  reset, synchronous and active-low.
REQ-005 f_req  input  1  fetch-port request; held high until f_valid.
REQ-006 f_addr  input  AW  fetch-port read address.
REQ-007 f_gnt  output  1  fetch-port access in progress (ACCESS state, fetch winner).
REQ-008 f_valid  output  1  one-cycle pulse: f_rdata valid.
REQ-009 f_rdata  output  DW  fetch read data.
REQ-010 d_req  input  1  data-port request (ld/sd); held high until d_valid.
REQ-011 d_we  input  1  data-port write enable (1 = sd, 0 = ld).
REQ-012 d_addr  input  AW  data-port address.
REQ-013 d_wdata  input  DW  data-port write data.
REQ-014 d_gnt  output  1  data-port access in progress (ACCESS state, data winner).
REQ-015 d_valid  output  1  one-cycle pulse: read data valid or write complete.
REQ-016 d_rdata  output  DW  data-port read data.
REQ-017 ram_addr  output  AW  RAM address, registered.
REQ-018 ram_wren  output  1  RAM write enable, registered.
REQ-019 ram_wdata  output  DW  RAM write data, registered.
REQ-020 ram_q  input  DW  RAM read data; one-cycle synchronous read latency.
REQ-021 busy  output  1  high in ACCESS and RESP.

Function
REQ-022 FSM SHALL have three states: IDLE, ACCESS, RESP.
REQ-023 IDLE: no request -> stay IDLE.
REQ-024 IDLE: any request -> choose winner, register winner's address/we/wdata into ram_addr/ram_wren/ram_wdata, go to ACCESS.
REQ-025 Fetch port SHALL only read: ram_wren = 0 for fetch wins.
REQ-026 Only f_req high -> fetch wins; only d_req high -> data wins.
REQ-027 Both high -> round-robin: the port not served last wins; last-winner flag SHALL update on every grant.
REQ-028 ACCESS: winner's gnt = 1, other gnt = 0; ram_* held; unconditional transition to RESP.
REQ-029 RESP: ram_wren SHALL be 0; winner's valid = 1 for exactly one cycle; unconditional transition to IDLE.
REQ-030 RESP read: winner's rdata SHALL equal ram_q.
REQ-031 RESP write: d_valid = 1 as completion ack; d_rdata = 0.
REQ-032 f_rdata/d_rdata SHALL be 0 whenever the corresponding valid is 0.
REQ-033 Latency: request sampled in IDLE at cycle N -> gnt in N+1 -> valid in N+2 -> next arbitration in N+3; peak throughput one access per 3 cycles.
REQ-034 Request inputs SHALL be ignored in ACCESS and RESP; dropping a request mid-transaction SHALL NOT abort it (address captured in IDLE).
REQ-035 The served port deasserts its request the cycle after valid; a request still high in the following IDLE SHALL be treated as new.
REQ-036 ram_wren SHALL be high for exactly one cycle (ACCESS) per write and never for a fetch.
REQ-037 Both valids SHALL never be high in the same cycle; both gnts SHALL never be high in the same cycle.

Reset
REQ-038 Resetn = 0 at a rising edge -> state IDLE; gnts, valids, busy, ram_wren = 0; ram_addr, ram_wdata, rdata = 0.
REQ-039 Reset SHALL set the last-winner flag to data, so fetch wins the first contended grant.
REQ-040 Reset in ACCESS or RESP SHALL abort the transaction: no valid pulse; write enable dropped in the same edge.

Verification
REQ-041 Reset then f_req = 1, f_addr = 0x0004, RAM[4] = 0x1234 -> f_gnt at cycle 1, f_valid with f_rdata = 0x1234 at cycle 2, busy high for cycles 1-2.
REQ-042 d_req = 1, d_we = 1, d_addr = 0x0010, d_wdata = 0xBEEF -> ram_wren one cycle with ram_addr = 0x0010; d_valid next cycle; later d_we = 0 read returns 0xBEEF.
REQ-043 f_req and d_req both held high from reset -> grants alternate fetch, data, fetch, data; each valid spaced 3 cycles apart.
REQ-044 d_req dropped during ACCESS -> transaction completes; d_valid still pulses; no further grant.
REQ-045 Resetn low during a write ACCESS -> ram_wren = 0 next edge, no d_valid, FSM in IDLE; a fresh request then completes normally.
